// File: rtl/uart_rx_sipo_if.sv
// Signal bundle between the UART receiver and its surroundings.
// The serial line comes in; the received byte, parity bit, flags and FSM state go out.
interface uart_rx_sipo_if;
  logic       data_rx;
  logic       parity_type;
  logic [7:0] data_out;
  logic       parity_rx;
  logic       active_flag;
  logic       done_flag;
  logic       frame_error;
  logic       parity_error;
  logic [2:0] fsm_state;

  // done_flag is a one-cycle valid strobe with no ready: data_out, parity_rx and
  // both error flags are valid with it and hold until the next strobe.
  modport master (
    output data_rx, parity_type,
    input  data_out, parity_rx, active_flag, done_flag,
    input  frame_error, parity_error, fsm_state
  );

  modport slave (
    input  data_rx, parity_type,
    output data_out, parity_rx, active_flag, done_flag,
    output frame_error, parity_error, fsm_state
  );
endinterface

// File: rtl/uart_rx_sipo.sv
// Oversampling UART receiver for an 11-bit frame: start, 8 data bits LSB first, parity, stop.
// Optional macro PARITY_CHECK_EN enables the parity_error check against parity_type.
module uart_rx_sipo #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           baud_clk,
  input  logic           reset_n,
  uart_rx_sipo_if.slave  rx
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, DONE, BREAK_WAIT
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line;
  logic [TW-1:0]          tick_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift_q;
  logic                   par_q;
  logic                   stop_q;
  logic                   bit_end;
  logic                   sample_data, sample_par, sample_stop, load_out;

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], rx.data_rx};
  end

  assign line         = sync_q[SYNC_STAGES-1];
  assign bit_end      = (tick_cnt == TICK_END);
  assign rx.fsm_state = state;

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (!line) state_n = START;
      START:      if (tick_cnt == TICK_MID) state_n = line ? IDLE : DATA;
      DATA:       if (bit_end && bit_cnt == 3'd7) state_n = PARITY;
      PARITY:     if (bit_end) state_n = STOP;
      STOP:       if (bit_end) state_n = DONE;
      // A low stop bit may be a break; wait for the line to recover before rearming.
      DONE:       state_n = stop_q ? IDLE : BREAK_WAIT;
      BREAK_WAIT: if (line) state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  always_comb begin
    rx.active_flag = 1'b0;
    sample_data    = 1'b0;
    sample_par     = 1'b0;
    sample_stop    = 1'b0;
    load_out       = 1'b0;
    case (state)
      START:  rx.active_flag = 1'b1;
      DATA:   begin rx.active_flag = 1'b1; sample_data = bit_end; end
      PARITY: begin rx.active_flag = 1'b1; sample_par  = bit_end; end
      STOP:   begin rx.active_flag = 1'b1; sample_stop = bit_end; end
      DONE:   begin rx.active_flag = 1'b1; load_out    = 1'b1;    end
      default: ;
    endcase
  end

`ifdef PARITY_CHECK_EN
  logic ptype_q;
`else
  logic unused_parity_type;
  assign unused_parity_type = rx.parity_type;
`endif

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt        <= '0;
      bit_cnt         <= '0;
      shift_q         <= '0;
      par_q           <= 1'b0;
      stop_q          <= 1'b1;
      rx.data_out     <= '0;
      rx.parity_rx    <= 1'b0;
      rx.done_flag    <= 1'b0;
      rx.frame_error  <= 1'b0;
      rx.parity_error <= 1'b0;
`ifdef PARITY_CHECK_EN
      ptype_q         <= 1'b0;
`endif
    end else begin
      rx.done_flag <= load_out;
      if (state == START)
        tick_cnt <= (tick_cnt == TICK_MID) ? '0 : tick_cnt + 1'b1;
      else if (state == DATA || state == PARITY || state == STOP)
        tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
      else
        tick_cnt <= '0;

      if (state == START)   bit_cnt <= '0;
      else if (sample_data) bit_cnt <= bit_cnt + 1'b1;

      // LSB arrives first, so each new bit enters at the top and walks down.
      if (sample_data) shift_q <= {line, shift_q[7:1]};
      if (sample_par) begin
        par_q <= line;
`ifdef PARITY_CHECK_EN
        ptype_q <= rx.parity_type;
`endif
      end
      if (sample_stop) stop_q <= line;

      if (load_out) begin
        rx.data_out    <= shift_q;
        rx.parity_rx   <= par_q;
        rx.frame_error <= ~stop_q;
`ifdef PARITY_CHECK_EN
        rx.parity_error <= ((^shift_q) ^ par_q) != ptype_q;
`else
        rx.parity_error <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sipo.sv
// Self-checking bench for uart_rx_sipo: directed frames, glitch, break, reset and random traffic.
module tb_uart_rx_sipo;
  localparam int OS = 16;
  localparam int SS = 2;
  localparam int LATENCY = SS + 1 + OS / 2 + 10 * OS + 1;

  logic baud_clk = 1'b0;
  logic reset_n;
  always #5 baud_clk = ~baud_clk;

  uart_rx_sipo_if uif();

  uart_rx_sipo #(.OVERSAMPLE(OS), .SYNC_STAGES(SS)) dut (
    .baud_clk (baud_clk),
    .reset_n  (reset_n),
    .rx       (uif.slave)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;
  int start_cyc = 0;
  int active_cnt = 0;
  int done_cyc[$];
  logic prev_done = 1'b0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_exp;

  always @(posedge baud_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected frame result: {parity_error, frame_error, parity_rx, data}.
  function automatic logic [10:0] model(input logic [7:0] d, input logic pbit,
                                        input logic stop, input logic ptype);
    logic pe;
`ifdef PARITY_CHECK_EN
    pe = (((^d) ^ pbit) != ptype);
`else
    pe = 1'b0;
`endif
    return {pe, ~stop, pbit, d};
  endfunction

  task automatic send_bit(input logic b);
    uif.data_rx = b;
    repeat (OS) @(negedge baud_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                            input logic ptype);
    uif.parity_type = ptype;
    exp_q.push_back(model(d, pbit, stop, ptype));
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(pbit);
    send_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    uif.data_rx = 1'b1;
    repeat (n * OS) @(negedge baud_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out"}, 32'(uif.data_out), 32'h0);
    check({tag, "_parity_rx"}, 32'(uif.parity_rx), 32'h0);
    check({tag, "_active"}, 32'(uif.active_flag), 32'h0);
    check({tag, "_done"}, 32'(uif.done_flag), 32'h0);
    check({tag, "_frame_error"}, 32'(uif.frame_error), 32'h0);
    check({tag, "_parity_error"}, 32'(uif.parity_error), 32'h0);
  endtask

  // Scoreboard: every done pulse is matched against the oldest expected frame.
  always @(negedge baud_clk) begin
    if (uif.active_flag) active_cnt <= active_cnt + 1;
    if (uif.done_flag) begin
      done_cyc.push_back(cyc);
      check("done_single_cycle", 32'(prev_done), 32'h0);
      check("done_latency", 32'(cyc - start_cyc), 32'(LATENCY));
      check("frame_expected", 32'(exp_q.size() > 0), 32'h1);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("data_out", 32'(uif.data_out), 32'(mon_exp[7:0]));
        check("parity_rx", 32'(uif.parity_rx), 32'(mon_exp[8]));
        check("frame_error", 32'(uif.frame_error), 32'(mon_exp[9]));
        check("parity_error", 32'(uif.parity_error), 32'(mon_exp[10]));
      end
    end
    prev_done <= uif.done_flag;
  end

  initial begin
    int n0;
    logic [7:0] d;
    logic pt, pb, sb;

    reset_n = 1'b0;
    uif.data_rx = 1'b1;
    uif.parity_type = 1'b0;
    repeat (3) @(negedge baud_clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    idle_bits(2);

    // 0xA5 even parity, clean frame; active window is about 10.5 bit times.
    active_cnt = 0;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    idle_bits(2);
    check("a5_active_len", 32'((active_cnt >= OS * 21 / 2) && (active_cnt <= OS * 21 / 2 + 1)), 32'h1);
    check("a5_idle_active", 32'(uif.active_flag), 32'h0);

    // 0x00 odd parity with correct, then wrong, parity bit.
    send_frame(8'h00, 1'b1, 1'b1, 1'b1);
    idle_bits(1);
    send_frame(8'h00, 1'b0, 1'b1, 1'b1);
    idle_bits(2);

    // Short glitch on the line must not produce a frame.
    n0 = done_cyc.size();
    uif.data_rx = 1'b0;
    repeat (4) @(negedge baud_clk);
    uif.data_rx = 1'b1;
    repeat (2) @(negedge baud_clk);
    check("glitch_active_high", 32'(uif.active_flag), 32'h1);
    repeat (OS) @(negedge baud_clk);
    check("glitch_back_idle", 32'(uif.active_flag), 32'h0);
    check("glitch_no_done", 32'(done_cyc.size()), 32'(n0));
    check("glitch_data_kept", 32'(uif.data_out), 32'h00);

    // 0x3C with a low stop bit and the line held low: one done, then break wait.
    n0 = done_cyc.size();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (3 * OS) @(negedge baud_clk);
    check("break_inactive", 32'(uif.active_flag), 32'h0);
    check("break_one_done", 32'(done_cyc.size()), 32'(n0 + 1));
    idle_bits(2);
    check("break_no_retrigger", 32'(done_cyc.size()), 32'(n0 + 1));
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    idle_bits(2);

    // Reset mid-frame after three data bits of 0xFF.
    n0 = done_cyc.size();
    uif.parity_type = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    reset_n = 1'b0;
    @(negedge baud_clk);
    check_reset_outputs("midreset");
    uif.data_rx = 1'b1;
    reset_n = 1'b1;
    idle_bits(2);
    check("midreset_no_done", 32'(done_cyc.size()), 32'(n0));
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    idle_bits(2);

    // Back-to-back frames with no idle gap.
    n0 = done_cyc.size();
    send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    send_frame(8'h80, 1'b1, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    idle_bits(2);
    check("b2b_count", 32'(done_cyc.size()), 32'(n0 + 3));
    if (done_cyc.size() >= n0 + 3) begin
      check("b2b_gap1", 32'(done_cyc[n0 + 1] - done_cyc[n0]), 32'(11 * OS));
      check("b2b_gap2", 32'(done_cyc[n0 + 2] - done_cyc[n0 + 1]), 32'(11 * OS));
    end

    // Random frames: random data, parity type, parity correctness and stop bit.
    for (int k = 0; k < 12; k++) begin
      d  = 8'($urandom_range(0, 255));
      pt = 1'($urandom_range(0, 1));
      pb = ($urandom_range(0, 1) == 1) ? ((^d) ^ pt) : ~((^d) ^ pt);
      sb = ($urandom_range(0, 3) != 0);
      send_frame(d, pb, sb, pt);
      if (!sb) idle_bits(int'($urandom_range(1, 3)));
      else     idle_bits(int'($urandom_range(0, 2)));
    end
    idle_bits(2);

    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge baud_clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_sipo.md
Name: uart_rx_sipo

Overview:
Serial-in/parallel-out UART receiver; the downstream counterpart of the TX PISO stage, consuming the serial line it drives. Frame format is fixed at 11 bits: start(0), 8 data bits LSB first, parity, stop(1). The line is oversampled on baud_clk at OVERSAMPLE x baud rate and sampled once per bit at mid-bit. Outputs the data byte, the received parity bit and error flags, with a 1-cycle done strobe.

Parameters:
OVERSAMPLE, 16, baud_clk ticks per bit; even, >= 8
SYNC_STAGES, 2, metastability flops on data_rx; >= 2

Ports:
baud_clk  in  1  receive clock, OVERSAMPLE x baud rate
reset_n  in  1  asynchronous active-low reset
data_rx  in  1  serial line, idle high, asynchronous to baud_clk
parity_type  in  1  0 = even, 1 = odd; sampled during the PARITY state
data_out  out  8  last received byte
parity_rx  out  1  parity bit as received
active_flag  out  1  high while a frame is in progress (START..STOP)
done_flag  out  1  1-cycle pulse: frame complete, outputs valid
frame_error  out  1  stop bit sampled 0; valid with done_flag, held until next done
parity_error  out  1  parity mismatch; valid with done_flag, held until next done

Behaviour:
- Clock is baud_clk; reset is asynchronous, active-low (reset_n); one clock domain.
- Reset values: data_out=0x00, parity_rx=0, active_flag=0, done_flag=0, frame_error=0, parity_error=0, synchronizer flops=1, state=IDLE, counters=0.
- data_rx passes through SYNC_STAGES flops; "line" below means the synchronized value.
- tick_cnt (width clog2(OVERSAMPLE)) counts baud_clk cycles within a bit; bit_cnt (3 bits) counts data bits.
- IDLE: line==0 -> START, tick_cnt=0. Otherwise stay.
- START: tick_cnt increments. At tick_cnt==OVERSAMPLE/2-1 (mid start bit): line==0 -> DATA, tick_cnt=0, bit_cnt=0; line==1 -> glitch, return to IDLE with no flags.
- DATA: sample when tick_cnt==OVERSAMPLE-1, then tick_cnt=0. Shift register shifts right, with the sampled bit entering bit 7 (LSB-first reconstruction). After the sample with bit_cnt==7 -> PARITY; otherwise bit_cnt+1.
- PARITY: sample at tick_cnt==OVERSAMPLE-1 into parity holding reg -> STOP.
- STOP: sample at tick_cnt==OVERSAMPLE-1. On the next edge: data_out<=shift reg, parity_rx<=parity reg, frame_error<=~sample, parity_error updated, done_flag=1 for exactly one cycle.
  - Stop sample 1 -> IDLE.
  - Stop sample 0 -> BREAK_WAIT.
- BREAK_WAIT: stay until line==1, then IDLE. This prevents retriggering on a held-low line.
- active_flag=1 in START, DATA, PARITY and STOP; 0 in IDLE and BREAK_WAIT.
- data_out updates on every completed frame, including errored frames; the error flags qualify it.
- Latency: done_flag asserts 1 cycle after the mid-stop-bit sample, i.e. about 10.5 bit times plus SYNC_STAGES+1 cycles after the falling edge of the start bit.
- Back-to-back frames: a start bit immediately after the stop bit is detected from IDLE with no lost frame. Mid-stop sampling leaves half a bit of margin.
- reset_n asserted mid-frame: immediate return to reset values; the partial frame is discarded with no done_flag.

Optional Feature:
PARITY_CHECK_EN
- Defined: parity_error = (XOR of the 8 data bits XOR the received parity bit) != parity_type, registered with done_flag.
- Undefined: parity_error is tied to 0 and the parity_type input is ignored. parity_rx is still captured, so parity can be checked downstream.

Test Plan:
- 0xA5, even parity (line 0,1,0,1,0,0,1,0,1,0,1) -> one done_flag pulse, data_out=0xA5, parity_rx=0, frame_error=0, parity_error=0; active_flag high for ~10.5 bit times.
- 0x00, parity_type=1, parity bit 1 -> data_out=0x00, parity_rx=1, parity_error=0. Repeat with parity bit 0 -> parity_error=1 (macro defined) / 0 (undefined).
- data_rx low for 4 ticks then high -> active_flag pulses, returns to IDLE by tick 8, no done_flag, outputs unchanged.
- 0x3C with stop bit 0 and line held low 3 bit times -> done_flag once, frame_error=1, data_out=0x3C, no second frame until the line goes high. Then 0x5A valid -> frame_error=0.
- reset_n pulsed after 3 data bits of 0xFF -> all outputs return to reset values, no done_flag. Following 0x3C frame -> data_out=0x3C.
- Frames 0x01, 0x80, 0xFF back-to-back with no idle gap -> three done_flag pulses, exactly 11 bit times apart, values correct in order.
